// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp codes for the traffic phase scheduler.
package traffic_pkg;

    typedef enum logic [7:0] {
        ST_A_GREEN  = 8'b0000_0001,
        ST_A_YELLOW = 8'b0000_0010,
        ST_ALLRED_AB = 8'b0000_0100,
        ST_B_GREEN  = 8'b0000_1000,
        ST_B_YELLOW = 8'b0001_0000,
        ST_ALLRED_BA = 8'b0010_0000,
        ST_WALK_A   = 8'b0100_0000,
        ST_WALK_B   = 8'b1000_0000
    } state_t;

    // Compact 3-bit phase index presented on the debug port
    localparam logic [2:0] PH_A_GREEN   = 3'd0;
    localparam logic [2:0] PH_A_YELLOW  = 3'd1;
    localparam logic [2:0] PH_ALLRED_AB = 3'd2;
    localparam logic [2:0] PH_B_GREEN   = 3'd3;
    localparam logic [2:0] PH_B_YELLOW  = 3'd4;
    localparam logic [2:0] PH_ALLRED_BA = 3'd5;
    localparam logic [2:0] PH_WALK_A    = 3'd6;
    localparam logic [2:0] PH_WALK_B    = 3'd7;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    function automatic logic [2:0] phase_code(input state_t s);
        logic [2:0] p;
        p = PH_ALLRED_BA;
        case (s)
            ST_A_GREEN:   p = PH_A_GREEN;
            ST_A_YELLOW:  p = PH_A_YELLOW;
            ST_ALLRED_AB: p = PH_ALLRED_AB;
            ST_B_GREEN:   p = PH_B_GREEN;
            ST_B_YELLOW:  p = PH_B_YELLOW;
            ST_ALLRED_BA: p = PH_ALLRED_BA;
            ST_WALK_A:    p = PH_WALK_A;
            ST_WALK_B:    p = PH_WALK_B;
            default:      p = PH_ALLRED_BA;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_tick_prescaler.sv
// Free-running clock divider producing a one-cycle tick every CLK_PER_TICK clocks.
module tick_prescaler #(
    parameter int CLK_PER_TICK = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(CLK_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick    = (count_q == LAST);
    assign count_d = tick ? '0 : count_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end
endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-approach intersection controller with pedestrian walk phases.
//   state        | meaning
//   A_GREEN      | A has right of way, rests here without conflicting demand
//   A_YELLOW     | A clearing
//   ALLRED_AB    | clearance before B (or walk)
//   B_GREEN      | B has right of way
//   B_YELLOW     | B clearing
//   ALLRED_BA    | clearance before A (or walk); reset state
//   WALK_A/B     | pedestrian walk, both approaches red
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CLK_PER_TICK = 4,
    parameter int MIN_GREEN    = 3,
    parameter int MAX_GREEN    = 6,
    parameter int YELLOW_T     = 2,
    parameter int ALLRED_T     = 1,
    parameter int WALK_T       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       ped_req,
    output logic [2:0] light_A,
    output logic [2:0] light_B,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);
    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       ped_q, ped_d;
    logic       tick;
    logic       in_green, enter_walk;

    tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_A_GREEN:   if (tick && timer_q >= 8'(MIN_GREEN - 1) && (req_b || ped_q)) state_d = ST_A_YELLOW;
            ST_A_YELLOW:  if (tick && timer_q == 8'(YELLOW_T - 1)) state_d = ST_ALLRED_AB;
            ST_ALLRED_AB: if (tick && timer_q == 8'(ALLRED_T - 1)) state_d = ped_q ? ST_WALK_A : ST_B_GREEN;
            ST_WALK_A:    if (tick && timer_q == 8'(WALK_T - 1)) state_d = ST_B_GREEN;
            ST_B_GREEN:   if (tick && timer_q >= 8'(MIN_GREEN - 1) && (req_a || ped_q)) state_d = ST_B_YELLOW;
            ST_B_YELLOW:  if (tick && timer_q == 8'(YELLOW_T - 1)) state_d = ST_ALLRED_BA;
            ST_ALLRED_BA: if (tick && timer_q == 8'(ALLRED_T - 1)) state_d = ped_q ? ST_WALK_B : ST_A_GREEN;
            ST_WALK_B:    if (tick && timer_q == 8'(WALK_T - 1)) state_d = ST_A_GREEN;
            default:      state_d = ST_ALLRED_BA;
        endcase
    end

    assign in_green   = (state_q == ST_A_GREEN) || (state_q == ST_B_GREEN);
    assign enter_walk = (state_d != state_q) && ((state_d == ST_WALK_A) || (state_d == ST_WALK_B));
    // Set wins over the clear on the walk-entry edge
    assign ped_d      = ped_req || (ped_q && !enter_walk);

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (tick) begin
            if (in_green && timer_q >= 8'(MAX_GREEN - 1)) timer_d = 8'(MAX_GREEN - 1);
            else                                          timer_d = timer_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ALLRED_BA;
            timer_q <= '0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ped_q   <= ped_d;
        end
    end

    always_comb begin
        light_A = LAMP_RED;
        light_B = LAMP_RED;
        walk    = 1'b0;
        case (state_q)
            ST_A_GREEN:  light_A = LAMP_GREEN;
            ST_A_YELLOW: light_A = LAMP_YELLOW;
            ST_B_GREEN:  light_B = LAMP_GREEN;
            ST_B_YELLOW: light_B = LAMP_YELLOW;
            ST_WALK_A,
            ST_WALK_B:   walk = 1'b1;
            default:     ;
        endcase
    end

    assign ped_pending = ped_q;
    assign phase       = phase_code(state_q);
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized bench for traffic_phase_scheduler against a tick-counting phase model.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam int CPT = 4, MING = 3, MAXG = 6, YT = 2, ART = 1, WT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, ped_req = 1'b0;
    logic [2:0] light_A, light_B, phase;
    logic walk, ped_pending;

    int checks = 0;
    int failures = 0;

    int m_ph, m_pc, m_ticks;
    bit m_ped;
    int pa, pb, pp;

    traffic_phase_scheduler #(
        .CLK_PER_TICK(CPT), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
        .YELLOW_T(YT), .ALLRED_T(ART), .WALK_T(WT)
    ) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
        .light_A(light_A), .light_B(light_B), .walk(walk),
        .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] lamp_a(input int p);
        if (p == PH_A_GREEN)  return LAMP_GREEN;
        if (p == PH_A_YELLOW) return LAMP_YELLOW;
        return LAMP_RED;
    endfunction

    function automatic logic [2:0] lamp_b(input int p);
        if (p == PH_B_GREEN)  return LAMP_GREEN;
        if (p == PH_B_YELLOW) return LAMP_YELLOW;
        return LAMP_RED;
    endfunction

    task automatic model_reset();
        m_ph = PH_ALLRED_BA; m_pc = 0; m_ticks = 0; m_ped = 0;
    endtask

    // Predicts the state after the coming rising edge from the inputs now applied
    task automatic model_step(input bit ra, input bit rb, input bit pr);
        bit tk;
        int nxt;
        tk  = (m_pc == CPT - 1);
        nxt = m_ph;
        m_pc = (m_pc + 1) % CPT;
        if (tk) begin
            case (m_ph)
                PH_A_GREEN:   if (m_ticks >= MING - 1 && (rb || m_ped)) nxt = PH_A_YELLOW;
                PH_B_GREEN:   if (m_ticks >= MING - 1 && (ra || m_ped)) nxt = PH_B_YELLOW;
                PH_A_YELLOW:  if (m_ticks == YT - 1) nxt = PH_ALLRED_AB;
                PH_B_YELLOW:  if (m_ticks == YT - 1) nxt = PH_ALLRED_BA;
                PH_ALLRED_AB: if (m_ticks == ART - 1) nxt = m_ped ? PH_WALK_A : PH_B_GREEN;
                PH_ALLRED_BA: if (m_ticks == ART - 1) nxt = m_ped ? PH_WALK_B : PH_A_GREEN;
                PH_WALK_A:    if (m_ticks == WT - 1) nxt = PH_B_GREEN;
                PH_WALK_B:    if (m_ticks == WT - 1) nxt = PH_A_GREEN;
                default:      nxt = PH_ALLRED_BA;
            endcase
        end
        if (nxt != m_ph && (nxt == PH_WALK_A || nxt == PH_WALK_B)) m_ped = pr;
        else                                                      m_ped = m_ped | pr;
        if (nxt != m_ph) begin
            m_ph = nxt; m_ticks = 0;
        end else if (tk) m_ticks++;
    endtask

    task automatic check_outputs();
        chk("light_A", 8'(light_A), 8'(lamp_a(m_ph)));
        chk("light_B", 8'(light_B), 8'(lamp_b(m_ph)));
        chk("walk", 8'(walk), 8'(m_ph == PH_WALK_A || m_ph == PH_WALK_B));
        chk("ped_pending", 8'(ped_pending), 8'(m_ped));
        chk("phase", 8'(phase), 8'(m_ph));
        chk("safe", 8'(light_A != LAMP_RED && light_B != LAMP_RED), 8'd0);
        chk("walk_red", 8'(walk && (light_A != LAMP_RED || light_B != LAMP_RED)), 8'd0);
    endtask

    task automatic drive_step();
        if ($urandom_range(0, 15) == 0) req_a = ($urandom_range(0, 99) < pa);
        if ($urandom_range(0, 15) == 0) req_b = ($urandom_range(0, 99) < pb);
        ped_req = ($urandom_range(0, 99) < pp);
        model_step(req_a, req_b, ped_req);
    endtask

    task automatic set_seg(input int a, input int b, input int p);
        pa = a; pb = b; pp = p;
        req_a = ($urandom_range(0, 99) < pa);
        req_b = ($urandom_range(0, 99) < pb);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            drive_step();
        end
    endtask

    initial begin
        bit reached;
        model_reset();
        set_seg(0, 0, 0);
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        drive_step();

        // Idle, B-only demand, then both approaches saturated
        run_cycles(250);
        set_seg(0, 100, 0);
        run_cycles(150);
        set_seg(100, 100, 0);
        run_cycles(200);

        // Asynchronous reset landing in A_YELLOW
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            check_outputs();
            drive_step();
            reached = (m_ph == PH_A_YELLOW);
        end
        chk("reach_yellow", 8'(reached), 8'd1);
        @(posedge clk);
        #2;
        chk("pre_rst_phase", 8'(phase), 8'(m_ph));
        rst = 1'b0;
        #1;
        chk("arst_light_A", 8'(light_A), 8'(LAMP_RED));
        chk("arst_light_B", 8'(light_B), 8'(LAMP_RED));
        chk("arst_walk", 8'(walk), 8'd0);
        chk("arst_phase", 8'(phase), 8'(PH_ALLRED_BA));
        chk("arst_ped", 8'(ped_pending), 8'd0);
        model_reset();
        set_seg(0, 0, 0);
        ped_req = 1'b0;
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        drive_step();
        run_cycles(100);

        // Random demand mixes, including near-continuous pedestrian requests
        for (int s = 0; s < 10; s++) begin
            set_seg($urandom_range(0, 100), $urandom_range(0, 100),
                    (s % 3 == 0) ? 70 : $urandom_range(0, 5));
            run_cycles(300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
